// File: rtl/cache_controller_pkg.sv
// cache_controller_pkg: widths, cache geometry, FSM encoding and the block word-select helper
// shared by the data cache controller and its storage.
package cache_controller_pkg;
    localparam int ADDRESS_LEN = 32;
    localparam int REGISTER_LEN = 32;
    localparam int CACHE_SETS = 64;
    localparam int CACHE_INDEX_LEN = 6;
    localparam int CACHE_TAG_LEN = 9;
    localparam int CACHE_BLOCK_LEN = 64;

    typedef enum logic [1:0] {
        CACHE_IDLE      = 2'b00,
        CACHE_READ_MISS = 2'b01,
        CACHE_WRITE     = 2'b10
    } cache_state_t;

    // Offset 0 is the word stored in the upper half of the block.
    function automatic logic [REGISTER_LEN-1:0] block_word(input logic [CACHE_BLOCK_LEN-1:0] block,
                                                           input logic offset);
        return offset ? block[31:0] : block[63:32];
    endfunction
endpackage

// File: rtl/cache_controller_memory.sv
// cache_memory: two-way tag/data storage with valid and lru state; lookup is combinational,
// fill/invalidate/touch update on the clock edge.
module cache_memory
    import cache_controller_pkg::*;
#(
    parameter int SETS = CACHE_SETS,
    parameter int TAG_LEN = CACHE_TAG_LEN,
    parameter int INDEX_LEN = CACHE_INDEX_LEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INDEX_LEN-1:0]       index,
    input  logic [TAG_LEN-1:0]         tag,
    input  logic                       offset,
    output logic                       hit,
    output logic                       hit_way,
    output logic [REGISTER_LEN-1:0]    hit_word,
    output logic                       victim,
    input  logic                       fill,
    input  logic [INDEX_LEN-1:0]       fill_index,
    input  logic                       fill_way,
    input  logic [TAG_LEN-1:0]         fill_tag,
    input  logic [CACHE_BLOCK_LEN-1:0] fill_block,
    input  logic                       invalidate,
    input  logic [INDEX_LEN-1:0]       invalidate_index,
    input  logic                       invalidate_way,
    input  logic                       touch,
    input  logic [INDEX_LEN-1:0]       touch_index,
    input  logic                       touch_way
);
    logic [SETS-1:0][1:0]       valid;
    logic [SETS-1:0]            lru;
    logic [TAG_LEN-1:0]         tags [SETS][2];
    logic [CACHE_BLOCK_LEN-1:0] data [SETS][2];
    logic [1:0]                 match;

    assign match[0] = valid[index][0] && tags[index][0] == tag;
    assign match[1] = valid[index][1] && tags[index][1] == tag;
    assign hit      = |match;
    assign hit_way  = !match[0];
    assign hit_word = block_word(data[index][hit_way], offset);
    // Empty ways are filled before anything is evicted.
    assign victim   = !valid[index][0] ? 1'b0 : !valid[index][1] ? 1'b1 : lru[index];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            lru   <= '0;
        end else begin
            if (invalidate) valid[invalidate_index][invalidate_way] <= 1'b0;
            if (fill) begin
                valid[fill_index][fill_way] <= 1'b1;
                lru[fill_index]             <= ~fill_way;
            end
            if (touch) lru[touch_index] <= ~touch_way;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tags[fill_index][fill_way] <= fill_tag;
            data[fill_index][fill_way] <= fill_block;
        end
    end
endmodule

// File: rtl/cache_controller.sv
// cache_controller: two-way write-through, no-write-allocate data cache between the MEM stage
// and the SRAM controller; read hits answer combinationally, misses and writes freeze the pipe.
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int SETS = CACHE_SETS,
    parameter int TAG_LEN = CACHE_TAG_LEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       read_enable,
    input  logic                       write_enable,
    input  logic [ADDRESS_LEN-1:0]     address,
    input  logic [REGISTER_LEN-1:0]    write_data,
    output logic [REGISTER_LEN-1:0]    read_data,
    output logic                       ready,
    output logic                       sram_read_enable,
    output logic                       sram_write_enable,
    output logic [ADDRESS_LEN-1:0]     sram_address,
    output logic [REGISTER_LEN-1:0]    sram_write_data,
    input  logic [CACHE_BLOCK_LEN-1:0] sram_read_data,
    input  logic                       sram_ready
);
    localparam int INDEX_LEN = $clog2(SETS);

    cache_state_t             ps, ns;
    logic [INDEX_LEN-1:0]     index;
    logic [TAG_LEN-1:0]       tag;
    logic                     offset, hit, hit_way, victim, fill, invalidate, touch;
    logic [REGISTER_LEN-1:0]  hit_word;

    assign offset          = address[2];
    assign index           = address[3 +: INDEX_LEN];
    assign tag             = address[3 + INDEX_LEN +: TAG_LEN];
    assign sram_address    = address;
    assign sram_write_data = write_data;

    cache_memory #(.SETS(SETS), .TAG_LEN(TAG_LEN), .INDEX_LEN(INDEX_LEN)) memory (
        .clk              (clk),
        .rst              (rst),
        .index            (index),
        .tag              (tag),
        .offset           (offset),
        .hit              (hit),
        .hit_way          (hit_way),
        .hit_word         (hit_word),
        .victim           (victim),
        .fill             (fill),
        .fill_index       (index),
        .fill_way         (victim),
        .fill_tag         (tag),
        .fill_block       (sram_read_data),
        .invalidate       (invalidate),
        .invalidate_index (index),
        .invalidate_way   (hit_way),
        .touch            (touch),
        .touch_index      (index),
        .touch_way        (hit_way)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ps <= CACHE_IDLE;
        else      ps <= ns;
    end

    always_comb begin
        ns                = ps;
        ready             = 1'b1;
        sram_read_enable  = 1'b0;
        sram_write_enable = 1'b0;
        read_data         = '0;
        fill              = 1'b0;
        invalidate        = 1'b0;
        touch             = 1'b0;
        case (ps)
            CACHE_IDLE:
                if (read_enable) begin
                    touch            = hit;
                    ready            = hit;
                    read_data        = hit ? hit_word : '0;
                    sram_read_enable = !hit;
                    ns               = hit ? CACHE_IDLE : CACHE_READ_MISS;
                end else if (write_enable) begin
                    invalidate        = hit;
                    ready             = 1'b0;
                    sram_write_enable = 1'b1;
                    ns                = CACHE_WRITE;
                end
            CACHE_READ_MISS: begin
                sram_read_enable = 1'b1;
                ready            = sram_ready;
                fill             = sram_ready;
                read_data        = sram_ready ? block_word(sram_read_data, offset) : '0;
                ns               = sram_ready ? CACHE_IDLE : CACHE_READ_MISS;
            end
            CACHE_WRITE: begin
                sram_write_enable = 1'b1;
                ready             = sram_ready;
                ns                = sram_ready ? CACHE_IDLE : CACHE_WRITE;
            end
            default: ns = CACHE_IDLE;
        endcase
        // While reset is held the enables must drop at once, not after the state register clears.
        if (!rst) begin
            ready             = 1'b1;
            sram_read_enable  = 1'b0;
            sram_write_enable = 1'b0;
            read_data         = '0;
            fill              = 1'b0;
            invalidate        = 1'b0;
            touch             = 1'b0;
        end
    end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: scoreboard bench with a behavioural SRAM and a timestamp-LRU cache model.
module tb_cache_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        read_enable, write_enable;
    logic [31:0] address, write_data, read_data;
    logic        ready, sram_read_enable, sram_write_enable;
    logic [31:0] sram_address, sram_write_data;
    logic [63:0] sram_read_data;
    logic        sram_ready;

    cache_controller dut (
        .clk               (clk),
        .rst               (rst),
        .read_enable       (read_enable),
        .write_enable      (write_enable),
        .address           (address),
        .write_data        (write_data),
        .read_data         (read_data),
        .ready             (ready),
        .sram_read_enable  (sram_read_enable),
        .sram_write_enable (sram_write_enable),
        .sram_address      (sram_address),
        .sram_write_data   (sram_write_data),
        .sram_read_data    (sram_read_data),
        .sram_ready        (sram_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_read;
        bit          hit;
        logic [31:0] data;
        int          wait_cycles;
    } exp_t;

    exp_t        q[$];
    int          checks = 0, errors = 0;
    int          exp_txns = 0, sram_txns = 0;
    bit          mon_en = 1'b0;

    // Reference: coherent word memory plus, per set, two ways stamped with last-use time.
    bit          mv [64][2];
    logic [8:0]  mt [64][2];
    int unsigned ms [64][2];
    int unsigned now_t;
    logic [31:0] ref_mem [int];
    logic [31:0] sram_mem [int];

    function automatic logic [31:0] mem_init(input int k);
        return (k * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int k = int'(a[17:2]);
        return ref_mem.exists(k) ? ref_mem[k] : mem_init(k);
    endfunction

    function automatic logic [31:0] sram_word(input logic [31:0] a);
        int k = int'(a[17:2]);
        return sram_mem.exists(k) ? sram_mem[k] : mem_init(k);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 64; s++)
            for (int w = 0; w < 2; w++) begin
                mv[s][w] = 1'b0;
                ms[s][w] = 0;
            end
        now_t = 0;
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int   idx, w, n;
        idx = int'(a[8:3]);
        w = -1;
        for (int i = 0; i < 2; i++) if (mv[idx][i] && mt[idx][i] == a[17:9]) w = i;
        e.is_read     = rd;
        e.hit         = (w >= 0);
        e.data        = rd ? ref_word(a) : 32'h0;
        e.wait_cycles = (rd && w >= 0) ? 0 : 6;
        now_t++;
        if (rd) begin
            if (w < 0) begin
                w = !mv[idx][0] ? 0 : !mv[idx][1] ? 1 : (ms[idx][0] < ms[idx][1] ? 0 : 1);
                mv[idx][w] = 1'b1;
                mt[idx][w] = a[17:9];
                exp_txns++;
            end
            ms[idx][w] = now_t;
        end else begin
            if (w >= 0) mv[idx][w] = 1'b0;
            ref_mem[int'(a[17:2])] = wd;
            exp_txns++;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        read_enable  = rd;
        write_enable = wr;
        address      = a;
        write_data   = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 20);
        if (!ready) begin
            errors++;
            $display("FAIL request_timeout: ready still %0b after %0d cycles at address %0h", ready, n, a);
            finish_run();
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        address      = $urandom;
        write_data   = $urandom;
        repeat (n - 1) @(posedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a = '0;
        a[17:9] = 9'($urandom_range(0, 3));
        a[8:3]  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 1));
        a[2]    = 1'($urandom);
        return a;
    endfunction

    // SRAM controller model: six cycles of enable, then a one-cycle ready pulse.
    initial begin
        int          cnt = 0;
        bit          en_r, rd_r;
        logic [31:0] a_r, wd_r;
        sram_ready     = 1'b0;
        sram_read_data = '0;
        forever begin
            @(negedge clk);
            en_r = rst && (sram_read_enable || sram_write_enable);
            rd_r = sram_read_enable;
            a_r  = sram_address;
            wd_r = sram_write_data;
            if (en_r) chk("sram_exclusive", 64'(sram_read_enable & sram_write_enable), 64'd0);
            @(posedge clk);
            #1;
            if (sram_ready) begin
                sram_ready     = 1'b0;
                sram_read_data = '0;
                cnt            = 0;
            end else if (en_r) begin
                cnt++;
                if (cnt == 6) begin
                    cnt        = 0;
                    sram_ready = 1'b1;
                    sram_txns++;
                    if (rd_r) sram_read_data = {sram_word(a_r & 32'hFFFF_FFF8), sram_word(a_r | 32'h4)};
                    else      sram_mem[int'(a_r[17:2])] = wd_r;
                end
            end else cnt = 0;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT completes a request.
    initial begin
        exp_t e;
        int   waitc = 0;
        forever begin
            @(negedge clk);
            if (!rst || !mon_en) waitc = 0;
            else if (read_enable || write_enable) begin
                if (q.size() == 0) chk("scoreboard_depth", 64'(q.size()), 64'd1);
                else begin
                    e = q[0];
                    chk("passthru", {sram_address, sram_write_data}, {address, write_data});
                    chk("sram_enables", {sram_read_enable, sram_write_enable},
                        e.is_read ? {!e.hit, 1'b0} : 2'b01);
                    if (!ready) begin
                        waitc++;
                        chk("read_data_busy", read_data, 0);
                    end else begin
                        void'(q.pop_front());
                        chk("latency", 64'(waitc), 64'(e.wait_cycles));
                        chk("read_data", read_data, e.data);
                        waitc = 0;
                    end
                end
            end else chk("idle_outputs", {ready, sram_read_enable, sram_write_enable, read_data}, {1'b1, 2'b00, 32'h0});
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time %0t exceeded", $time);
        finish_run();
    end

    initial begin
        logic [31:0] a;
        int          op;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        address      = '0;
        write_data   = '0;
        model_reset();
        sram_mem[4] = 32'hAAAA_AAAA;
        sram_mem[5] = 32'h5555_5555;
        ref_mem[4]  = 32'hAAAA_AAAA;
        ref_mem[5]  = 32'h5555_5555;
        @(negedge clk);
        read_enable = 1'b1;
        address     = 32'h0000_0040;
        @(negedge clk);
        chk("reset_outputs", {ready, sram_read_enable, sram_write_enable, read_data}, {1'b1, 2'b00, 32'h0});
        @(posedge clk);
        #1;
        read_enable = 1'b0;
        rst         = 1'b1;
        mon_en      = 1'b1;

        issue(1, 0, 32'h10, 0);
        issue(1, 0, 32'h14, 0);
        issue(0, 1, 32'h10, 32'h1234_5678);
        issue(1, 0, 32'h10, 0);
        idle(1);
        issue(1, 0, 32'h008, 0);
        issue(1, 0, 32'h208, 0);
        issue(1, 0, 32'h408, 0);
        issue(1, 0, 32'h008, 0);
        issue(1, 0, 32'h208, 0);
        issue(1, 1, 32'h1018, 32'hDEAD_BEEF);
        idle(2);

        // Reset in the middle of a miss abandons the fill.
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        read_enable = 1'b1;
        address     = 32'h0003_F000;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_abort", {ready, sram_read_enable, sram_write_enable, read_data}, {1'b1, 2'b00, 32'h0});
        model_reset();
        @(negedge clk);
        @(posedge clk);
        #1;
        read_enable = 1'b0;
        rst         = 1'b1;
        mon_en      = 1'b1;
        issue(1, 0, 32'h0003_F000, 0);
        issue(1, 0, 32'h0003_F004, 0);

        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 99);
            a  = rand_addr();
            if (op < 65)      issue(1, 0, a, 0);
            else if (op < 90) issue(0, 1, a, $urandom);
            else if (op < 95) issue(1, 1, a, $urandom);
            else              idle($urandom_range(1, 3));
        end
        idle(3);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        chk("sram_transactions", 64'(sram_txns), 64'(exp_txns));
        finish_run();
    end
endmodule
